// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the IS61WV25616 n-beat SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    ACK
  } sram_state_e;

  // Width of one SRAM data beat (the device is x16).
  localparam int unsigned HW_W = 16;

  // $clog2 that never returns 0, so counters always have at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_is61wv25616_ctrl_nbeat_beat_timer.sv
// Beat / wait-state counter pair for one access direction.
// Counts wait 0..WAIT-1 per beat, then advances the beat; the beat never wraps.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BEATS = 2,
  parameter int unsigned WAIT  = 1,
  localparam int unsigned BW = clog2_min1(BEATS),
  localparam int unsigned WW = clog2_min1(WAIT)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_run,
  output logic [BW-1:0] beat,
  output logic          last_wait,
  output logic          last_beat
);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT - 1);

  logic [BW-1:0] beat_q;
  logic [WW-1:0] wait_q;

  assign beat      = beat_q;
  assign last_wait = (wait_q == WAIT_LAST);
  assign last_beat = (beat_q == BEAT_LAST);

  // Advance wait within a beat, then step to the next beat (saturating at the last).
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      beat_q <= '0;
      wait_q <= '0;
    end else if (i_run) begin
      if (last_wait) begin
        wait_q <= '0;
        if (!last_beat) beat_q <= beat_q + BW'(1);
      end else begin
        wait_q <= wait_q + WW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_is61wv25616_ctrl_nbeat.sv
// IS61WV25616 (256Kx16) async-SRAM controller: one DATA_W access split into
// DATA_W/16 halfword beats with per-beat wait states, busy handshake and
// back-to-back acceptance in the ACK cycle.
module sram_is61wv25616_ctrl_nbeat
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [17:0]         i_ADDR,
  input  logic [DATA_W-1:0]   i_WDATA,
  input  logic [DATA_W/8-1:0] i_BMASK,
  input  logic                i_WREN,
  input  logic                i_RDEN,
  output logic [DATA_W-1:0]   o_RDATA,
  output logic                o_ACK,
  output logic                o_BUSY,
  output logic [17:0]         SRAM_ADDR,
  inout  wire logic [15:0]    SRAM_DQ,
  output logic                SRAM_CE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_UB_N
);

  localparam int unsigned BEATS = DATA_W / HW_W;
  localparam int unsigned BW    = clog2_min1(BEATS);
  localparam logic [17:0] ADDR_MASK = (BEATS > 1) ? ~18'((1 << BW) - 1) : '1;

  sram_state_e state_q, state_d;

  logic [17:0]         addr_q;
  logic [DATA_W/8-1:0] bmask_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic          accept, in_write, in_read;
  logic [BW-1:0] wr_beat, rd_beat, beat_sel;
  logic          wr_last_wait, wr_last_beat, rd_last_wait, rd_last_beat;
  logic [HW_W-1:0] dq_out;
  logic [1:0]      lanes_n;

  assign in_write = (state_q == WRITE);
  assign in_read  = (state_q == READ);
  assign accept   = ((state_q == IDLE) || (state_q == ACK)) && (i_WREN ^ i_RDEN);
  assign beat_sel = in_read ? rd_beat : wr_beat;

  sram_beat_timer #(.BEATS(BEATS), .WAIT(WRITE_WAIT)) u_wr_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (accept),
    .i_run     (in_write),
    .beat      (wr_beat),
    .last_wait (wr_last_wait),
    .last_beat (wr_last_beat)
  );

  sram_beat_timer #(.BEATS(BEATS), .WAIT(READ_WAIT)) u_rd_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (accept),
    .i_run     (in_read),
    .beat      (rd_beat),
    .last_wait (rd_last_wait),
    .last_beat (rd_last_beat)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: accept from IDLE/ACK, finish after the last wait of the last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACK: begin
        if (accept) state_d = i_WREN ? WRITE : READ;
        else        state_d = IDLE;
      end
      WRITE:   if (wr_last_wait && wr_last_beat) state_d = ACK;
      READ:    if (rd_last_wait && rd_last_beat) state_d = ACK;
      default: state_d = IDLE;
    endcase
  end

  // Request latching and per-beat capture of read data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q  <= '0;
      bmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= i_ADDR & ADDR_MASK;
        bmask_q <= i_BMASK;
        if (i_WREN) wdata_q <= i_WDATA;
      end
      if (in_read && rd_last_wait) begin
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (rd_beat == BW'(k)) rdata_q[k*HW_W +: HW_W] <= SRAM_DQ;
        end
      end
    end
  end

  // Select the current beat's write halfword and byte-lane enables.
  always_comb begin
    dq_out  = '0;
    lanes_n = 2'b11;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_sel == BW'(k)) begin
        dq_out  = wdata_q[k*HW_W +: HW_W];
        lanes_n = ~bmask_q[2*k +: 2];
      end
    end
  end

  // The aligned address has zeros in the beat field, so OR-ing in the beat
  // equals {addr_q[17:BW], beat}; with one beat the beat is always 0.
  assign SRAM_ADDR = addr_q | 18'(beat_sel);
  assign SRAM_CE_N = !(in_write || in_read);
  assign SRAM_WE_N = !in_write;
  assign SRAM_OE_N = !in_read;
  assign SRAM_LB_N = o_BUSY ? lanes_n[0] : 1'b1;
  assign SRAM_UB_N = o_BUSY ? lanes_n[1] : 1'b1;
  assign SRAM_DQ   = in_write ? dq_out : 'z;

  assign o_ACK   = (state_q == ACK);
  assign o_BUSY  = in_write || in_read;
  assign o_RDATA = rdata_q;

endmodule

// File: tb/tb_sram_is61wv25616_ctrl_nbeat.sv
// Scoreboard bench: a default 32-bit controller and a 64-bit / READ_WAIT=3
// controller, each wired to a behavioural SRAM. Issued requests push the
// expected response (data, ACK cycle, pin pattern) from a word-level memory model.
module tb_sram_is61wv25616_ctrl_nbeat;

  localparam int RW1  = 3;
  localparam int WW1  = 2;
  localparam int MEMN = 1024;

  typedef struct {
    bit          rd;
    logic [63:0] data;
    logic [17:0] base;
    logic [7:0]  mask;
    int          due;
    int          bn;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: defaults
  logic [17:0] addr0;  logic [31:0] wdata0; logic [3:0] bmask0;
  logic wren0, rden0, ack0, busy0, ce0, we_n0, oe0, lb0, ub0;
  logic [31:0] rd0;    logic [17:0] sa0;    wire [15:0] dq0;

  // DUT1: 64-bit, READ_WAIT=3, WRITE_WAIT=2
  logic [17:0] addr1;  logic [63:0] wdata1; logic [7:0] bmask1;
  logic wren1, rden1, ack1, busy1, ce1, we_n1, oe1, lb1, ub1;
  logic [63:0] rd1;    logic [17:0] sa1;    wire [15:0] dq1;

  sram_is61wv25616_ctrl_nbeat dut0 (
    .i_clk(clk), .i_reset(rst), .i_ADDR(addr0), .i_WDATA(wdata0), .i_BMASK(bmask0),
    .i_WREN(wren0), .i_RDEN(rden0), .o_RDATA(rd0), .o_ACK(ack0), .o_BUSY(busy0),
    .SRAM_ADDR(sa0), .SRAM_DQ(dq0), .SRAM_CE_N(ce0), .SRAM_WE_N(we_n0),
    .SRAM_OE_N(oe0), .SRAM_LB_N(lb0), .SRAM_UB_N(ub0)
  );

  sram_is61wv25616_ctrl_nbeat #(.DATA_W(64), .READ_WAIT(RW1), .WRITE_WAIT(WW1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_ADDR(addr1), .i_WDATA(wdata1), .i_BMASK(bmask1),
    .i_WREN(wren1), .i_RDEN(rden1), .o_RDATA(rd1), .o_ACK(ack1), .o_BUSY(busy1),
    .SRAM_ADDR(sa1), .SRAM_DQ(dq1), .SRAM_CE_N(ce1), .SRAM_WE_N(we_n1),
    .SRAM_OE_N(oe1), .SRAM_LB_N(lb1), .SRAM_UB_N(ub1)
  );

  // Behavioural SRAMs (low 10 address bits; all bench traffic stays below 0x400)
  logic [15:0] mem0 [MEMN];
  logic [15:0] mem1 [MEMN];
  assign dq0 = (!ce0 && !oe0 && we_n0) ? mem0[sa0[9:0]] : 16'hzzzz;
  assign dq1 = (!ce1 && !oe1 && we_n1) ? mem1[sa1[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce0 && !we_n0) begin
      if (!lb0) mem0[sa0[9:0]][7:0]  = dq0[7:0];
      if (!ub0) mem0[sa0[9:0]][15:8] = dq0[15:8];
    end
    if (!ce1 && !we_n1) begin
      if (!lb1) mem1[sa1[9:0]][7:0]  = dq1[7:0];
      if (!ub1) mem1[sa1[9:0]][15:8] = dq1[15:8];
    end
  end

  // Reference word memory and scoreboard
  logic [15:0] ref0 [MEMN];
  logic [15:0] ref1 [MEMN];
  exp_t q0[$];
  exp_t q1[$];
  logic [63:0] last_rd [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic ack, input logic busy, input logic ce,
                     input logic wen, input logic oen, input logic lb, input logic ub,
                     input logic [17:0] sa, input logic [63:0] rd);
    exp_t e;
    bit   have;
    bit   busy_exp;
    int   beat;
    logic [7:0] m;
    have = 1'b0;
    e.due = 0;
    if (d == 0) begin
      if (q0.size() > 0) begin have = 1'b1; e = q0[0]; end
    end else begin
      if (q1.size() > 0) begin have = 1'b1; e = q1[0]; end
    end
    busy_exp = have && (cyc < e.due);
    chk($sformatf("busy%0d", d), 64'(busy), 64'(busy_exp));
    if (busy_exp) begin
      beat = (cyc - (e.due - e.bn)) / e.n;
      m = e.mask >> (2 * beat);
      chk($sformatf("addr%0d", d), 64'(sa), 64'(e.base + 18'(beat)));
      chk($sformatf("ctl%0d", d), 64'({ce, wen, oen}), 64'({1'b0, e.rd, !e.rd}));
      chk($sformatf("lanes%0d", d), 64'({ub, lb}), 64'({~m[1], ~m[0]}));
    end
    if (ack && !have) begin
      chk($sformatf("spurious_ack%0d", d), 64'(have), 64'd1);
    end else if (have && cyc >= e.due) begin
      chk($sformatf("ack_time%0d", d), 64'(ack), 64'd1);
      if (ack && e.rd) chk($sformatf("rdata%0d", d), rd, e.data);
      if (e.rd) last_rd[d] = e.data;
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end else if (ack) begin
      chk($sformatf("ack_early%0d", d), 64'(cyc), 64'(e.due));
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (!busy_exp) begin
      chk($sformatf("idle_pins%0d", d), 64'({ce, wen, oen, ub, lb}), 64'h1F);
      chk($sformatf("rdata_hold%0d", d), rd, last_rd[d]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, ack0, busy0, ce0, we_n0, oe0, lb0, ub0, sa0, 64'(rd0));
    mon(1, ack1, busy1, ce1, we_n1, oe1, lb1, ub1, sa1, rd1);
  end

  // Drive one cycle of request on DUT d; model the access if it will be accepted.
  task automatic step(input int d, input bit we, input bit re, input logic [17:0] a,
                      input logic [63:0] w, input logic [7:0] m);
    exp_t e;
    int   beats;
    int   idx;
    logic [15:0] h;
    bit   busy_now;
    if (d == 0) begin
      wren0 = we; rden0 = re; addr0 = a; wdata0 = w[31:0]; bmask0 = m[3:0];
      busy_now = busy0;
    end else begin
      wren1 = we; rden1 = re; addr1 = a; wdata1 = w; bmask1 = m;
      busy_now = busy1;
    end
    if ((we ^ re) && !busy_now) begin
      beats  = (d == 0) ? 2 : 4;
      e.n    = we ? ((d == 0) ? 1 : WW1) : ((d == 0) ? 2 : RW1);
      e.rd   = re;
      e.base = a & ~18'(beats - 1);
      e.mask = (d == 0) ? {4'h0, m[3:0]} : m;
      e.bn   = beats * e.n;
      e.due  = cyc + e.bn + 1;
      e.data = '0;
      for (int k = 0; k < beats; k++) begin
        idx = int'(e.base) + k;
        h = (d == 0) ? ref0[idx] : ref1[idx];
        if (we) begin
          for (int b = 0; b < 2; b++)
            if (e.mask[2*k+b]) h[8*b +: 8] = w[16*k + 8*b +: 8];
          if (d == 0) ref0[idx] = h; else ref1[idx] = h;
        end else begin
          e.data[16*k +: 16] = h;
        end
      end
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) step(d, 1'b0, 1'b0, 18'h0, 64'h0, 8'h0);
  endtask

  initial begin
    int r;
    for (int i = 0; i < MEMN; i++) begin
      mem0[i] = '0; mem1[i] = '0; ref0[i] = '0; ref1[i] = '0;
    end
    last_rd[0] = '0; last_rd[1] = '0;
    wren0 = 0; rden0 = 0; addr0 = '0; wdata0 = '0; bmask0 = '0;
    wren1 = 0; rden1 = 0; addr1 = '0; wdata1 = '0; bmask1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_rdata0", 64'(rd0), 64'h0);
    chk("rst_rdata1", rd1, 64'h0);
    chk("rst_ackbusy0", 64'({ack0, busy0}), 64'h0);
    chk("rst_pins1", 64'({ce1, we_n1, oe1, lb1, ub1}), 64'h1F);

    // Full write, byte placement in the SRAM
    step(0, 1, 0, 18'h00013, 64'hDEADBEEF, 8'hF);
    idle(0, 4);
    chk("t2_mem_lo", 64'(mem0[18]), 64'hBEEF);
    chk("t2_mem_hi", 64'(mem0[19]), 64'hDEAD);

    // Read back
    step(0, 0, 1, 18'h00012, 64'h0, 8'hF);
    idle(0, 6);
    chk("t3_rdata", 64'(rd0), 64'hDEADBEEF);

    // Partial byte mask over all-ones
    step(0, 1, 0, 18'h00020, 64'hFFFFFFFF, 8'hF);
    idle(0, 4);
    step(0, 1, 0, 18'h00020, 64'h11223344, 8'h6);
    idle(0, 4);
    step(0, 0, 1, 18'h00021, 64'h0, 8'hF);
    idle(0, 6);
    chk("t4_rdata", 64'(rd0), 64'hFF2233FF);

    // Back-to-back: read issued in the write's ACK cycle; both-high ignored
    step(0, 1, 0, 18'h00030, 64'hA5A55A5A, 8'hF);
    idle(0, 2);
    chk("t5_in_ack", 64'({ack0, busy0}), 64'h2);
    step(0, 0, 1, 18'h00030, 64'h0, 8'hF);
    step(0, 1, 0, 18'h00031, 64'h12345678, 8'hF);
    step(0, 1, 1, 18'h00032, 64'h87654321, 8'hF);
    step(0, 0, 1, 18'h00033, 64'h0, 8'hF);
    step(0, 1, 1, 18'h00034, 64'h0, 8'hF);
    chk("t5_read_ack", 64'(ack0), 64'd1);
    step(0, 1, 1, 18'h00035, 64'hCAFEF00D, 8'hF);
    step(0, 1, 1, 18'h00036, 64'hCAFEF00D, 8'hF);
    idle(0, 3);

    // Reset during beat 1 of a read
    step(0, 0, 1, 18'h00012, 64'h0, 8'hF);
    idle(0, 2);
    rst = 1'b1;
    q0.delete(); q1.delete();
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk); #1;
    chk("t1_rdata", 64'(rd0), 64'h0);
    chk("t1_state", 64'({ack0, busy0, ce0, oe0}), 64'h3);
    rst = 1'b0;
    idle(0, 2);

    // Randomised traffic on the default controller
    repeat (300) begin
      r = $urandom_range(0, 9);
      step(0, (r < 4) || (r == 7), (r >= 4) && (r <= 7), 18'($urandom_range(0, 63)),
           {$urandom, $urandom}, 8'($urandom));
    end
    idle(0, 8);

    // 64-bit controller, unaligned address, READ_WAIT=3
    step(1, 1, 0, 18'h00105, 64'h0123456789ABCDEF, 8'hFF);
    idle(1, 10);
    chk("t6_mem_104", 64'(mem1[260]), 64'hCDEF);
    chk("t6_mem_107", 64'(mem1[263]), 64'h0123);
    step(1, 0, 1, 18'h00105, 64'h0, 8'hFF);
    idle(1, 15);
    chk("t6_rdata", rd1, 64'h0123456789ABCDEF);

    repeat (150) begin
      r = $urandom_range(0, 9);
      step(1, (r < 4) || (r == 7), (r >= 4) && (r <= 7), 18'($urandom_range(0, 63)),
           {$urandom, $urandom}, 8'($urandom));
    end
    idle(1, 16);

    chk("drain0", 64'(q0.size()), 64'h0);
    chk("drain1", 64'(q1.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
